// File: rtl/os_stream_cache.sv
// Output-stationary cache: weight/activation/psum storage with command-driven bursts
// and valid/ready streams toward the global buffer bus and the PE array.
module os_stream_cache #(
    parameter int WA_BITS = 8,
    parameter int WA_ROWS = 256,
    parameter int P_BITS  = 16,
    parameter int P_ROWS  = 32,
    parameter int AW      = $clog2(WA_ROWS)
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic               w_cmd_valid,
    input  logic [2:0]         w_cmd_op,
    input  logic [AW-1:0]      w_cmd_base_w,
    input  logic [AW-1:0]      w_cmd_base_a,
    input  logic [AW:0]        w_cmd_len,
    output logic               r_cmd_ready,
    input  logic               w_in_valid,
    input  logic [WA_BITS-1:0] w_in_data,
    output logic               r_in_ready,
    input  logic               w_glb_valid,
    input  logic [P_BITS-1:0]  w_glb_in,
    output logic               r_glb_ready,
    output logic               r_out_valid,
    input  logic               w_out_ready,
    output logic [WA_BITS-1:0] r_wout,
    output logic [WA_BITS-1:0] r_aout,
    output logic               r_bus_valid,
    input  logic               w_bus_ready,
    output logic [P_BITS-1:0]  r_bus_out,
    output logic               r_busy
);
    localparam int PW = $clog2(P_ROWS);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       CLR_LAST = (AW+1)'(P_ROWS - 1);
    localparam logic [AW-1:0]     ADDR_ONE = AW'(1);
    localparam logic [P_BITS-1:0] P_MAX    = {1'b0, {(P_BITS-1){1'b1}}};
    localparam logic [P_BITS-1:0] P_MIN    = {1'b1, {(P_BITS-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_W, S_LOAD_A, S_STREAM, S_LOAD_P, S_ACC_P, S_DRAIN, S_CLEAR, S_NOP
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_w_q, addr_w_d, addr_a_q, addr_a_d;
    logic [AW:0]         len_q, len_d, cnt_q, cnt_d, iss_q, iss_d;
    logic                out_valid_q, out_valid_d, bus_valid_q, bus_valid_d;
    logic [WA_BITS-1:0]  wout_q, wout_d, aout_q, aout_d;
    logic [P_BITS-1:0]   bus_out_q, bus_out_d;

    logic [WA_BITS-1:0]  mem_w [WA_ROWS];
    logic [WA_BITS-1:0]  mem_a [WA_ROWS];
    logic [P_BITS-1:0]   mem_p [P_ROWS];

    logic                we_w, we_a, we_p;
    logic [PW-1:0]       p_addr, p_waddr;
    logic [P_BITS-1:0]   p_rd, p_wdata, acc_sat;
    logic [P_BITS:0]     acc_sum;
    logic                in_hs, glb_hs, out_hs, bus_hs, last_beat;

    assign r_cmd_ready = (state_q == S_IDLE);
    assign r_busy      = (state_q != S_IDLE);
    assign r_in_ready  = (state_q == S_LOAD_W) || (state_q == S_LOAD_A);
    assign r_glb_ready = (state_q == S_LOAD_P) || (state_q == S_ACC_P);
    assign r_out_valid = out_valid_q;
    assign r_bus_valid = bus_valid_q;
    assign r_wout      = wout_q;
    assign r_aout      = aout_q;
    assign r_bus_out   = bus_out_q;

    assign in_hs     = w_in_valid && r_in_ready;
    assign glb_hs    = w_glb_valid && r_glb_ready;
    assign out_hs    = out_valid_q && w_out_ready;
    assign bus_hs    = bus_valid_q && w_bus_ready;
    assign last_beat = (cnt_q + CNT_ONE) == len_q;

    // Psum read is asynchronous so read-modify-write sustains one beat per cycle
    // even when a burst wraps onto the same row.
    assign p_addr = addr_w_q[PW-1:0];
    assign p_rd   = mem_p[p_addr];

    always_comb begin
        acc_sum = {p_rd[P_BITS-1], p_rd} + {w_glb_in[P_BITS-1], w_glb_in};
        acc_sat = acc_sum[P_BITS-1:0];
        if (acc_sum[P_BITS] != acc_sum[P_BITS-1]) begin
            acc_sat = acc_sum[P_BITS] ? P_MIN : P_MAX;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_w_d    = addr_w_q;
        addr_a_d    = addr_a_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        iss_d       = iss_q;
        out_valid_d = out_valid_q;
        bus_valid_d = bus_valid_q;
        wout_d      = wout_q;
        aout_d      = aout_q;
        bus_out_d   = bus_out_q;
        we_w        = 1'b0;
        we_a        = 1'b0;
        we_p        = 1'b0;
        p_waddr     = p_addr;
        p_wdata     = w_glb_in;
        case (state_q)
            S_IDLE: begin
                if (w_cmd_valid) begin
                    addr_w_d = w_cmd_base_w;
                    addr_a_d = w_cmd_base_a;
                    len_d    = w_cmd_len;
                    cnt_d    = '0;
                    iss_d    = '0;
                    case (w_cmd_op)
                        3'd0:    state_d = S_LOAD_W;
                        3'd1:    state_d = S_LOAD_A;
                        3'd2:    state_d = S_STREAM;
                        3'd3:    state_d = S_LOAD_P;
                        3'd4:    state_d = S_ACC_P;
                        3'd5:    state_d = S_DRAIN;
                        3'd6:    state_d = S_CLEAR;
                        default: state_d = S_NOP;
                    endcase
                    // Zero-length bursts spend their single busy cycle in S_NOP so no ready ever rises.
                    if ((w_cmd_len == '0) && (w_cmd_op != 3'd6)) state_d = S_NOP;
                end
            end
            S_LOAD_W, S_LOAD_A: begin
                if (in_hs) begin
                    we_w  = (state_q == S_LOAD_W);
                    we_a  = (state_q == S_LOAD_A);
                    if (state_q == S_LOAD_W) addr_w_d = addr_w_q + ADDR_ONE;
                    else                     addr_a_d = addr_a_q + ADDR_ONE;
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_beat) state_d = S_IDLE;
                end
            end
            S_LOAD_P, S_ACC_P: begin
                if (glb_hs) begin
                    we_p     = 1'b1;
                    p_wdata  = (state_q == S_ACC_P) ? acc_sat : w_glb_in;
                    addr_w_d = addr_w_q + ADDR_ONE;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (last_beat) state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if ((!out_valid_q || w_out_ready) && (iss_q != len_q)) begin
                    wout_d      = mem_w[addr_w_q];
                    aout_d      = mem_a[addr_a_q];
                    out_valid_d = 1'b1;
                    addr_w_d    = addr_w_q + ADDR_ONE;
                    addr_a_d    = addr_a_q + ADDR_ONE;
                    iss_d       = iss_q + CNT_ONE;
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                end
                if (out_hs) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_beat) state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if ((!bus_valid_q || w_bus_ready) && (iss_q != len_q)) begin
                    bus_out_d   = p_rd;
                    bus_valid_d = 1'b1;
                    addr_w_d    = addr_w_q + ADDR_ONE;
                    iss_d       = iss_q + CNT_ONE;
                end else if (bus_hs) begin
                    bus_valid_d = 1'b0;
                end
                if (bus_hs) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_beat) state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                we_p    = 1'b1;
                p_waddr = cnt_q[PW-1:0];
                p_wdata = '0;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CLR_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q     <= S_IDLE;
            addr_w_q    <= '0;
            addr_a_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            iss_q       <= '0;
            out_valid_q <= 1'b0;
            bus_valid_q <= 1'b0;
            wout_q      <= '0;
            aout_q      <= '0;
            bus_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_w_q    <= addr_w_d;
            addr_a_q    <= addr_a_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            iss_q       <= iss_d;
            out_valid_q <= out_valid_d;
            bus_valid_q <= bus_valid_d;
            wout_q      <= wout_d;
            aout_q      <= aout_d;
            bus_out_q   <= bus_out_d;
        end
    end

    // Storage is never reset; a reset landing on a beat suppresses that beat's write.
    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            if (we_w) mem_w[addr_w_q] <= w_in_data;
            if (we_a) mem_a[addr_a_q] <= w_in_data;
            if (we_p) mem_p[p_waddr]  <= p_wdata;
        end
    end
endmodule

// File: tb/tb_os_stream_cache.sv
// Directed bench for os_stream_cache: loads, streams with backpressure, saturating
// accumulation, wrap-around, clear, zero-length commands and mid-burst reset.
module tb_os_stream_cache;
    logic        w_clk = 1'b0;
    logic        w_rst, w_cmd_valid, w_in_valid, w_glb_valid, w_out_ready, w_bus_ready;
    logic [2:0]  w_cmd_op;
    logic [7:0]  w_cmd_base_w, w_cmd_base_a, w_in_data;
    logic [8:0]  w_cmd_len;
    logic [15:0] w_glb_in;
    logic        r_cmd_ready, r_in_ready, r_glb_ready, r_out_valid, r_bus_valid, r_busy;
    logic [7:0]  r_wout, r_aout;
    logic [15:0] r_bus_out;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] tx  [64];
    logic [15:0] got [64];

    always #5 w_clk = ~w_clk;

    os_stream_cache #(.WA_BITS(8), .WA_ROWS(256), .P_BITS(16), .P_ROWS(32), .AW(8)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .w_cmd_valid(w_cmd_valid), .w_cmd_op(w_cmd_op), .w_cmd_base_w(w_cmd_base_w),
        .w_cmd_base_a(w_cmd_base_a), .w_cmd_len(w_cmd_len), .r_cmd_ready(r_cmd_ready),
        .w_in_valid(w_in_valid), .w_in_data(w_in_data), .r_in_ready(r_in_ready),
        .w_glb_valid(w_glb_valid), .w_glb_in(w_glb_in), .r_glb_ready(r_glb_ready),
        .r_out_valid(r_out_valid), .w_out_ready(w_out_ready), .r_wout(r_wout), .r_aout(r_aout),
        .r_bus_valid(r_bus_valid), .w_bus_ready(w_bus_ready), .r_bus_out(r_bus_out),
        .r_busy(r_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [7:0] bw, input logic [7:0] ba,
                       input logic [8:0] len);
        chk("cmd_ready", {31'd0, r_cmd_ready}, 32'd1);
        w_cmd_valid = 1'b1; w_cmd_op = op; w_cmd_base_w = bw; w_cmd_base_a = ba; w_cmd_len = len;
        @(negedge w_clk);
        w_cmd_valid = 1'b0;
        $display("cmd op=%0d base_w=%0d base_a=%0d len=%0d", op, bw, ba, len);
    endtask

    task automatic send(input bit glb, input int n);
        for (int i = 0; i < n; i++) begin
            if (glb) begin
                w_glb_valid = 1'b1; w_glb_in = tx[i];
                chk("glb_ready", {31'd0, r_glb_ready}, 32'd1);
            end else begin
                w_in_valid = 1'b1; w_in_data = tx[i][7:0];
                chk("in_ready", {31'd0, r_in_ready}, 32'd1);
            end
            @(negedge w_clk);
        end
        w_in_valid = 1'b0; w_glb_valid = 1'b0;
        chk("load_done_busy", {31'd0, r_busy}, 32'd0);
    endtask

    task automatic collect(input bit bus, input int n, input int st_lo, input int st_hi);
        int          got_n = 0;
        int          cyc   = 0;
        int          extra = 0;
        bit          hp    = 1'b0;
        logic [15:0] held  = '0;
        logic [15:0] d;
        logic        v, rdy;
        while (got_n < n && cyc < 400) begin
            rdy = !(cyc >= st_lo && cyc <= st_hi);
            w_out_ready = rdy; w_bus_ready = rdy;
            v = bus ? r_bus_valid : r_out_valid;
            d = bus ? r_bus_out : {r_wout, r_aout};
            if (hp) begin
                chk("hold_valid", {31'd0, v}, 32'd1);
                chk("hold_stable", {16'd0, d}, {16'd0, held});
            end
            hp = 1'b0;
            if (v && rdy) begin
                got[got_n] = d; got_n++;
            end else if (v) begin
                hp = 1'b1; held = d;
            end
            cyc++;
            @(negedge w_clk);
        end
        chk("beat_count", got_n, n);
        chk("valid_drop", {31'd0, (bus ? r_bus_valid : r_out_valid)}, 32'd0);
        chk("busy_drop", {31'd0, r_busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge w_clk);
            extra += int'(r_out_valid) + int'(r_bus_valid);
        end
        chk("extra_beats", extra, 0);
        w_out_ready = 1'b0; w_bus_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [15:0] e;
        w_rst = 1'b1; w_cmd_valid = 1'b0; w_cmd_op = '0; w_cmd_base_w = '0; w_cmd_base_a = '0;
        w_cmd_len = '0; w_in_valid = 1'b0; w_in_data = '0; w_glb_valid = 1'b0; w_glb_in = '0;
        w_out_ready = 1'b0; w_bus_ready = 1'b0;
        repeat (3) @(negedge w_clk);
        w_rst = 1'b0;
        chk("rst_cmd_ready", {31'd0, r_cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, r_busy}, 32'd0);
        chk("rst_in_ready", {31'd0, r_in_ready}, 32'd0);
        chk("rst_glb_ready", {31'd0, r_glb_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, r_out_valid}, 32'd0);
        chk("rst_bus_valid", {31'd0, r_bus_valid}, 32'd0);
        chk("rst_data", {8'd0, r_wout, r_aout, 8'd0}, 32'd0);
        chk("rst_bus_out", {16'd0, r_bus_out}, 32'd0);

        // Weights 1..10 at 250 wrapping to 3; activations 0x80.. at 0
        for (int i = 0; i < 10; i++) tx[i] = 16'(i + 1);
        cmd(3'd0, 8'd250, 8'd0, 9'd10); send(1'b0, 10);
        for (int i = 0; i < 10; i++) tx[i] = 16'(8'h80 + i);
        cmd(3'd1, 8'd0, 8'd0, 9'd10); send(1'b0, 10);
        cmd(3'd2, 8'd250, 8'd0, 9'd10);
        chk("stream_busy", {31'd0, r_busy}, 32'd1);
        chk("first_valid_latency", {31'd0, r_out_valid}, 32'd0);
        collect(1'b0, 10, -1, -1);
        for (int i = 0; i < 10; i++) begin
            e = {8'(i + 1), 8'(8'h80 + i)};
            chk("stream_pair", {16'd0, got[i]}, {16'd0, e});
        end

        // Backpressure while the third beat is presented
        cmd(3'd2, 8'd250, 8'd0, 9'd4);
        collect(1'b0, 4, 3, 4);
        for (int i = 0; i < 4; i++) begin
            e = {8'(i + 1), 8'(8'h80 + i)};
            chk("stall_pair", {16'd0, got[i]}, {16'd0, e});
        end

        // CLEAR takes P_ROWS cycles, then drain shows zeros
        cmd(3'd6, 8'd7, 8'd0, 9'd3);
        c = 0;
        while (r_busy && c < 100) begin c++; @(negedge w_clk); end
        chk("clear_cycles", c, 32);
        cmd(3'd5, 8'd0, 8'd0, 9'd32);
        collect(1'b1, 32, -1, -1);
        for (int i = 0; i < 32; i++) chk("clear_zero", {16'd0, got[i]}, 32'd0);

        // 64 accumulates of +1 wrap twice over 32 rows
        for (int i = 0; i < 64; i++) tx[i] = 16'd1;
        cmd(3'd4, 8'd0, 8'd0, 9'd64); send(1'b1, 64);
        cmd(3'd5, 8'd0, 8'd0, 9'd32);
        collect(1'b1, 32, -1, -1);
        for (int i = 0; i < 32; i++) chk("acc_wrap", {16'd0, got[i]}, 32'd2);

        // Saturation: 32760+100 -> 32767, -32760-100 -> -32768; row6 2-3 -> -1
        tx[0] = 16'd32760;  cmd(3'd3, 8'd5, 8'd0, 9'd1); send(1'b1, 1);
        tx[0] = 16'd100;    cmd(3'd4, 8'd5, 8'd0, 9'd1); send(1'b1, 1);
        cmd(3'd5, 8'd5, 8'd0, 9'd1);
        collect(1'b1, 1, -1, -1);
        chk("sat_pos", {16'd0, got[0]}, 32'h7FFF);
        tx[0] = 16'h8008;   cmd(3'd3, 8'd5, 8'd0, 9'd1); send(1'b1, 1);
        tx[0] = 16'hFF9C;   cmd(3'd4, 8'd5, 8'd0, 9'd1); send(1'b1, 1);
        tx[0] = 16'hFFFD;   cmd(3'd4, 8'd6, 8'd0, 9'd1); send(1'b1, 1);
        cmd(3'd5, 8'd5, 8'd0, 9'd2);
        collect(1'b1, 2, -1, -1);
        chk("sat_neg", {16'd0, got[0]}, 32'h8000);
        chk("acc_signed", {16'd0, got[1]}, 32'hFFFF);

        // Reset at beat 3 of LOAD_A: rows 40..42 new, 43..47 keep the old values
        for (int i = 0; i < 8; i++) tx[i] = 16'(8'h11 * (i + 1));
        cmd(3'd1, 8'd0, 8'd40, 9'd8); send(1'b0, 8);
        for (int i = 0; i < 8; i++) tx[i] = 16'(8'hA0 + i);
        cmd(3'd1, 8'd0, 8'd40, 9'd8);
        for (int i = 0; i < 3; i++) begin
            w_in_valid = 1'b1; w_in_data = tx[i][7:0];
            @(negedge w_clk);
        end
        w_in_valid = 1'b1; w_in_data = tx[3][7:0]; w_rst = 1'b1;
        @(negedge w_clk);
        w_rst = 1'b0; w_in_valid = 1'b0;
        $display("reset asserted at beat 3 of LOAD_A");
        chk("abort_busy", {31'd0, r_busy}, 32'd0);
        chk("abort_cmd_ready", {31'd0, r_cmd_ready}, 32'd1);
        chk("abort_in_ready", {31'd0, r_in_ready}, 32'd0);
        cmd(3'd2, 8'd250, 8'd40, 9'd8);
        collect(1'b0, 8, -1, -1);
        for (int i = 0; i < 8; i++) begin
            e = {8'(i + 1), (i < 3) ? 8'(8'hA0 + i) : 8'(8'h11 * (i + 1))};
            chk("abort_rows", {16'd0, got[i]}, {16'd0, e});
        end

        // NOP and zero-length commands: one busy cycle, no ready, no write
        cmd(3'd7, 8'd0, 8'd0, 9'd5);
        chk("nop_busy", {31'd0, r_busy}, 32'd1);
        @(negedge w_clk);
        chk("nop_done", {31'd0, r_busy}, 32'd0);
        cmd(3'd0, 8'd0, 8'd0, 9'd0);
        w_in_valid = 1'b1; w_in_data = 8'hEE;
        chk("len0_busy", {31'd0, r_busy}, 32'd1);
        chk("len0_in_ready", {31'd0, r_in_ready}, 32'd0);
        @(negedge w_clk);
        w_in_valid = 1'b0;
        chk("len0_done", {31'd0, r_busy}, 32'd0);
        w_glb_valid = 1'b1;
        chk("idle_glb_ready", {31'd0, r_glb_ready}, 32'd0);
        @(negedge w_clk);
        w_glb_valid = 1'b0;
        cmd(3'd2, 8'd0, 8'd0, 9'd0);
        @(negedge w_clk);
        chk("len0_stream_valid", {31'd0, r_out_valid}, 32'd0);
        cmd(3'd2, 8'd0, 8'd0, 9'd1);
        collect(1'b0, 1, -1, -1);
        chk("len0_no_write", {16'd0, got[0]}, 32'h0780);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
